// File: rtl/data_mem_responder.sv
// CPU data-memory port bridged onto a registered classic bus (cyc/stb/ack) with lane steering and a bus timeout.
// Optional macro UNALIGNED_EXC_EN: misaligned half/word accesses raise mem_unalign instead of being aligned down.
module data_mem_responder #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [1:0]  mem_type,
    input  logic        mem_ext,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_unalign,
    output logic        mem_buserr,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    input  logic        bus_ack
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_BYTE = 2'b10;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  busy_cnt;
    logic        we_q;
    logic        byte_q;
    logic        half_q;
    logic        ext_q;
    logic [1:0]  low_q;
    logic [31:0] rdata_q;
    logic        buserr_q;

    logic        req;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        unalign_hit;
    logic        start;
    logic [1:0]  addr_low;

    // Byte lanes are little-endian: lane 0 carries bits 7:0 of the bus word.
    function automatic logic [3:0] lanes_for(input logic byte_acc, input logic half_acc,
                                             input logic [1:0] low);
        if (byte_acc)
            return 4'b0001 << low;
        if (half_acc)
            return low[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] replicate(input logic byte_acc, input logic half_acc,
                                              input logic [31:0] d);
        if (byte_acc)
            return {4{d[7:0]}};
        if (half_acc)
            return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] low,
                                            input logic byte_acc, input logic half_acc,
                                            input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{low, 3'b000} +: 8];
        h = low[1] ? w[31:16] : w[15:0];
        if (byte_acc)
            return {{24{sext & b[7]}}, b};
        if (half_acc)
            return {{16{sext & h[15]}}, h};
        return w;
    endfunction

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        req        = mem_ren | mem_wen;
        is_byte    = (mem_type == TYPE_BYTE);
        is_half    = (mem_type == TYPE_HALF);
        misaligned = 1'b0;
        addr_low   = mem_addr[1:0];
        if (is_half) begin
            misaligned  = mem_addr[0];
            addr_low[0] = 1'b0;
        end else if (!is_byte) begin
            misaligned = (mem_addr[1:0] != 2'b00);
            addr_low   = 2'b00;
        end
    end

`ifdef UNALIGNED_EXC_EN
    assign unalign_hit = misaligned;
`else
    assign unalign_hit = 1'b0;
`endif

    assign start = (state == IDLE) && req && !unalign_hit;

    // Combinational outputs are gated by rst_n so they read 0 the moment reset asserts.
    assign mem_stall   = rst_n & (start | (state == BUSY));
    assign mem_unalign = rst_n & (state == IDLE) & req & unalign_hit;
    assign mem_buserr  = buserr_q;
    assign mem_din     = ((state == DONE) && !we_q)
                         ? extract(rdata_q, low_q, byte_q, half_q, ext_q) : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy_cnt <= 8'd0;
            bus_cyc  <= 1'b0;
            bus_stb  <= 1'b0;
            bus_we   <= 1'b0;
            bus_addr <= 30'd0;
            bus_sel  <= 4'd0;
            bus_dout <= 32'd0;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            half_q   <= 1'b0;
            ext_q    <= 1'b0;
            low_q    <= 2'd0;
            rdata_q  <= 32'd0;
            buserr_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= BUSY;
                        busy_cnt <= 8'd0;
                        bus_cyc  <= 1'b1;
                        bus_stb  <= 1'b1;
                        bus_we   <= mem_wen;
                        bus_addr <= mem_addr[31:2];
                        bus_sel  <= lanes_for(is_byte, is_half, addr_low);
                        bus_dout <= replicate(is_byte, is_half, mem_dout);
                        we_q     <= mem_wen;
                        byte_q   <= is_byte;
                        half_q   <= is_half;
                        ext_q    <= mem_ext;
                        low_q    <= addr_low;
                        buserr_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        state   <= DONE;
                        rdata_q <= bus_din;
                        bus_cyc <= 1'b0;
                        bus_stb <= 1'b0;
                        bus_we  <= 1'b0;
                    end else if (busy_cnt == TIMEOUT_LAST) begin
                        state    <= DONE;
                        rdata_q  <= 32'd0;
                        buserr_q <= 1'b1;
                        bus_cyc  <= 1'b0;
                        bus_stb  <= 1'b0;
                        bus_we   <= 1'b0;
                    end else begin
                        busy_cnt <= busy_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    buserr_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver queues expected responses, a monitor checks each completion.
module tb_data_mem_responder;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  mem_type;
    logic        mem_ext;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        mem_unalign;
    logic        mem_buserr;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_dout;
    logic [31:0] bus_din;
    logic        bus_ack;

    logic        ack_gen = 1'b0;
    logic        late_ack = 1'b0;
    logic [31:0] rdata_cfg = 32'd0;
    int          ack_dly_cfg = 0;

    assign bus_ack = ack_gen | late_ack;
    assign bus_din = rdata_cfg;

    data_mem_responder #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_type(mem_type), .mem_ext(mem_ext),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_stall(mem_stall), .mem_unalign(mem_unalign), .mem_buserr(mem_buserr),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_dout(bus_dout), .bus_din(bus_din), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] din;
        int          buserr;
        logic        unalign;
        int          stall;
        int          cyc;
        logic        we;
        logic [29:0] addr;
        logic [3:0]  sel;
        logic [31:0] dout;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] din, input int buserr, input logic unalign,
                                input int stall, input int cyc, input logic we,
                                input logic [29:0] addr, input logic [3:0] sel,
                                input logic [31:0] dout);
        exp_t e;
        e.id = 0; e.din = din; e.buserr = buserr; e.unalign = unalign; e.stall = stall;
        e.cyc = cyc; e.we = we; e.addr = addr; e.sel = sel; e.dout = dout;
        return e;
    endfunction

    // Bus slave: acks in BUSY cycle number ack_dly_cfg (0 = first BUSY cycle).
    int busy_k = 0;
    always @(negedge clk) begin
        if (!rst_n || !bus_cyc) begin
            ack_gen = 1'b0;
            busy_k  = 0;
        end else begin
            ack_gen = (busy_k == ack_dly_cfg);
            busy_k++;
        end
    end

    // Monitor: accumulates bus/stall observations and scores them when the stall releases.
    int          stall_cnt = 0;
    int          cyc_cnt = 0;
    int          buserr_cnt = 0;
    logic        saw_unalign = 1'b0;
    logic        din_bad = 1'b0;
    logic        prev_stall = 1'b0;
    logic        rec_we = 1'b0;
    logic [29:0] rec_addr = '0;
    logic [3:0]  rec_sel = '0;
    logic [31:0] rec_dout = '0;

    always @(negedge clk) begin
        logic done_now;
        exp_t e;
        if (!rst_n) begin
            stall_cnt = 0; cyc_cnt = 0; buserr_cnt = 0;
            saw_unalign = 1'b0; din_bad = 1'b0; prev_stall = 1'b0;
        end else begin
            done_now = (prev_stall && !mem_stall) || (mem_unalign && !mem_stall);
            if (bus_cyc) begin
                cyc_cnt++;
                rec_we = bus_we; rec_addr = bus_addr; rec_sel = bus_sel; rec_dout = bus_dout;
            end
            if (mem_buserr) buserr_cnt++;
            if (mem_unalign) saw_unalign = 1'b1;
            if (mem_stall) stall_cnt++;
            if (!done_now && mem_din != 32'd0) din_bad = 1'b1;
            if (done_now) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("t%0d_din", e.id), mem_din, e.din);
                    check($sformatf("t%0d_stall_cycles", e.id), 32'(stall_cnt), 32'(e.stall));
                    check($sformatf("t%0d_cyc_cycles", e.id), 32'(cyc_cnt), 32'(e.cyc));
                    check($sformatf("t%0d_buserr_pulses", e.id), 32'(buserr_cnt), 32'(e.buserr));
                    check($sformatf("t%0d_unalign", e.id), 32'(saw_unalign), 32'(e.unalign));
                    check($sformatf("t%0d_din_zero_elsewhere", e.id), 32'(din_bad), 32'd0);
                    if (e.cyc > 0) begin
                        check($sformatf("t%0d_bus_we", e.id), 32'(rec_we), 32'(e.we));
                        check($sformatf("t%0d_bus_addr", e.id), 32'(rec_addr), 32'(e.addr));
                        check($sformatf("t%0d_bus_sel", e.id), 32'(rec_sel), 32'(e.sel));
                        if (e.we) check($sformatf("t%0d_bus_dout", e.id), rec_dout, e.dout);
                    end
                end
                stall_cnt = 0; cyc_cnt = 0; buserr_cnt = 0;
                saw_unalign = 1'b0; din_bad = 1'b0;
            end
            prev_stall = mem_stall;
        end
    end

    task automatic do_req(input int id, input logic ren, input logic wen, input logic [1:0] typ,
                          input logic ext, input logic [31:0] addr, input logic [31:0] wdata,
                          input int dly, input logic [31:0] rdata, input exp_t e);
        exp_t ee;
        int n;
        ee = e;
        ee.id = id;
        exp_q.push_back(ee);
        ack_dly_cfg = dly;
        rdata_cfg   = rdata;
        mem_ren = ren; mem_wen = wen; mem_type = typ; mem_ext = ext;
        mem_addr = addr; mem_dout = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_stall && n < 64);
        if (mem_stall) check($sformatf("t%0d_stall_release", id), 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        mem_ren = 1'b1; mem_wen = 1'b1; mem_type = 2'b00; mem_ext = 1'b0;
        mem_addr = 32'h0000_0104; mem_dout = 32'hFFFF_FFFF;
        #3;
        check("rst_mem_din", mem_din, 32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        check("rst_mem_unalign", 32'(mem_unalign), 32'd0);
        check("rst_mem_buserr", 32'(mem_buserr), 32'd0);
        check("rst_bus_cyc_stb", 32'({bus_cyc, bus_stb, bus_we}), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_sel", 32'(bus_sel), 32'd0);
        check("rst_bus_dout", bus_dout, 32'd0);
        mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = 32'd0; mem_dout = 32'd0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_no_stall", 32'(mem_stall), 32'd0);
            check("idle_no_cyc", 32'(bus_cyc), 32'd0);
        end
        @(posedge clk);
        #1;

        do_req(1, 0, 1, 2'b00, 0, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0,
               mk(32'h0, 0, 0, 4, 3, 1, 30'h40, 4'b1111, 32'hDEAD_BEEF));
        do_req(2, 1, 0, 2'b10, 1, 32'h0000_0103, 32'h0, 0, 32'h8012_3456,
               mk(32'hFFFF_FF80, 0, 0, 2, 1, 0, 30'h40, 4'b1000, 32'h0));
        do_req(3, 1, 0, 2'b10, 0, 32'h0000_0103, 32'h0, 0, 32'h8012_3456,
               mk(32'h0000_0080, 0, 0, 2, 1, 0, 30'h40, 4'b1000, 32'h0));
        do_req(4, 0, 1, 2'b01, 0, 32'h0000_0022, 32'hFFFF_1234, 0, 32'h0,
               mk(32'h0, 0, 0, 2, 1, 1, 30'h08, 4'b1100, 32'h1234_1234));
        do_req(5, 1, 0, 2'b00, 0, 32'h0000_0200, 32'h0, 255, 32'h1111_1111,
               mk(32'h0, 1, 0, 5, 4, 0, 30'h80, 4'b1111, 32'h0));
`ifdef UNALIGNED_EXC_EN
        do_req(6, 1, 0, 2'b00, 0, 32'h0000_0102, 32'h0, 1, 32'hCAFE_F00D,
               mk(32'h0, 0, 1, 0, 0, 0, 30'h0, 4'b0000, 32'h0));
`else
        do_req(6, 1, 0, 2'b00, 0, 32'h0000_0102, 32'h0, 1, 32'hCAFE_F00D,
               mk(32'hCAFE_F00D, 0, 0, 3, 2, 0, 30'h40, 4'b1111, 32'h0));
`endif
        do_req(7, 1, 0, 2'b01, 1, 32'h0000_0102, 32'h0, 0, 32'h8001_7FFF,
               mk(32'hFFFF_8001, 0, 0, 2, 1, 0, 30'h40, 4'b1100, 32'h0));
        do_req(8, 1, 0, 2'b10, 0, 32'h0000_0101, 32'h0, 0, 32'h0000_A500,
               mk(32'h0000_00A5, 0, 0, 2, 1, 0, 30'h40, 4'b0010, 32'h0));
        do_req(9, 0, 1, 2'b10, 0, 32'h0000_0005, 32'h1234_56AB, 1, 32'h0,
               mk(32'h0, 0, 0, 3, 2, 1, 30'h01, 4'b0010, 32'hABAB_ABAB));
        do_req(10, 1, 0, 2'b11, 1, 32'h0000_0010, 32'h0, 0, 32'h1234_5678,
               mk(32'h1234_5678, 0, 0, 2, 1, 0, 30'h04, 4'b1111, 32'h0));
`ifdef UNALIGNED_EXC_EN
        do_req(11, 1, 0, 2'b01, 1, 32'h0000_0041, 32'h0, 0, 32'h1234_F00F,
               mk(32'h0, 0, 1, 0, 0, 0, 30'h0, 4'b0000, 32'h0));
`else
        do_req(11, 1, 0, 2'b01, 1, 32'h0000_0041, 32'h0, 0, 32'h1234_F00F,
               mk(32'hFFFF_F00F, 0, 0, 2, 1, 0, 30'h10, 4'b0011, 32'h0));
`endif
        do_req(12, 1, 1, 2'b00, 0, 32'h0000_0080, 32'h55AA_55AA, 0, 32'hFFFF_FFFF,
               mk(32'h0, 0, 0, 2, 1, 1, 30'h20, 4'b1111, 32'h55AA_55AA));
        do_req(13, 1, 0, 2'b01, 0, 32'h0000_0000, 32'h0, 0, 32'h8001_8765,
               mk(32'h0000_8765, 0, 0, 2, 1, 0, 30'h00, 4'b0011, 32'h0));

        // Reset in the middle of a bus cycle, followed by a stray ack.
        ack_dly_cfg = 1000;
        mem_ren = 1'b1; mem_wen = 1'b0; mem_type = 2'b00; mem_addr = 32'h0000_0300;
        repeat (3) @(negedge clk);
        check("midrst_cyc_before", 32'(bus_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cyc_stb", 32'({bus_cyc, bus_stb}), 32'd0);
        check("midrst_stall", 32'(mem_stall), 32'd0);
        check("midrst_din", mem_din, 32'd0);
        check("midrst_bus_addr", 32'(bus_addr), 32'd0);
        mem_ren = 1'b0; mem_addr = 32'd0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        rdata_cfg = 32'hFFFF_FFFF;
        late_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("late_ack_stall", 32'(mem_stall), 32'd0);
            check("late_ack_cyc", 32'(bus_cyc), 32'd0);
            check("late_ack_din", mem_din, 32'd0);
        end
        late_ack = 1'b0;
        @(posedge clk);
        #1;

        do_req(14, 1, 0, 2'b10, 1, 32'h0000_0003, 32'h0, 0, 32'h7F00_0000,
               mk(32'h0000_007F, 0, 0, 2, 1, 0, 30'h00, 4'b1000, 32'h0));

        mem_ren = 1'b0; mem_wen = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("trailing_din_zero", 32'(din_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
